// File: rtl/cmp_pkg.sv
// Shared types and constants for the memory stage: FSM states, widths, stack reset value.
package cmp_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  localparam logic [DATA_W-1:0] SP_RESET = 16'h07FF;
  localparam logic [DATA_W-1:0] SP_ONE   = 16'h0001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_stage_stack_ptr.sv
// stack_ptr: stack pointer register with modulo-2^16 increment (pop) and decrement (push).
module stack_ptr
  import cmp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [DATA_W-1:0] sp,
  output logic [DATA_W-1:0] sp_up
);

  // A pop reads the slot above the current top, so sp+1 is exposed for addressing.
  assign sp_up = sp + SP_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= SP_RESET;
    end else if (inc) begin
      sp <= sp_up;
    end else if (dec) begin
      sp <= sp - SP_ONE;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: IDLE/ACCESS/RESP memory stage with load/store and an optional hardware stack.
// Stack support (push/pop, sp register) is compiled only when CMP_STACK_EN is defined.
module mem_stage
  import cmp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              push,
  input  logic              pop,
  input  logic              reg_write,
  input  logic [REG_W-1:0]  rdst,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rdst,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] sp
);

  state_t            state;
  logic [DATA_W-1:0] alu_p0;
  logic [REG_W-1:0]  rdst_p0;
  logic              rw_p0;
  logic              push_p0;
  logic              pop_p0;
  logic              stk_push;
  logic              stk_pop;
  logic [DATA_W-1:0] sp_cur;
  logic [DATA_W-1:0] sp_up;
  logic              is_mem;
  logic              accept;
  logic              ack_hit;

  assign ex_ready = (state == IDLE) && !rst;
  assign accept   = ex_valid && ex_ready;
  assign ack_hit  = (state == ACCESS) && dmem_ack && !rst;

`ifdef CMP_STACK_EN
  assign stk_push = push;
  assign stk_pop  = pop;

  stack_ptr u_stack_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (ack_hit && pop_p0),
    .dec   (ack_hit && push_p0),
    .sp    (sp_cur),
    .sp_up (sp_up)
  );
`else
  logic unused_stack;
  assign stk_push     = 1'b0;
  assign stk_pop      = 1'b0;
  assign sp_cur       = '0;
  assign sp_up        = '0;
  assign unused_stack = ^{push, pop, push_p0, pop_p0};
`endif

  assign sp     = sp_cur;
  assign is_mem = mem_read || mem_write || stk_push || stk_pop;

  // Accept boundary: the transaction fields are latched for the writeback bundle.
  always_ff @(posedge clk) begin
    if (accept) begin
      alu_p0  <= alu_out;
      rdst_p0 <= rdst;
      rw_p0   <= reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rdst      <= '0;
      wb_reg_write <= 1'b0;
      push_p0      <= 1'b0;
      pop_p0       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            push_p0 <= 1'b0;
            pop_p0  <= 1'b0;
            if (is_mem) begin
              state      <= ACCESS;
              dmem_req   <= 1'b1;
              dmem_wdata <= store_data;
              // Lower-priority requests in the same transaction are dropped.
              if (stk_push) begin
                dmem_we   <= 1'b1;
                dmem_addr <= sp_cur;
                push_p0   <= 1'b1;
              end else if (stk_pop) begin
                dmem_we   <= 1'b0;
                dmem_addr <= sp_up;
                pop_p0    <= 1'b1;
              end else if (mem_write) begin
                dmem_we   <= 1'b1;
                dmem_addr <= alu_out;
              end else begin
                dmem_we   <= 1'b0;
                dmem_addr <= alu_out;
              end
            end else begin
              state        <= RESP;
              wb_valid     <= 1'b1;
              wb_data      <= alu_out;
              wb_rdst      <= rdst;
              wb_reg_write <= reg_write;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            state        <= RESP;
            dmem_req     <= 1'b0;
            wb_valid     <= 1'b1;
            wb_data      <= dmem_we ? alu_p0 : dmem_rdata;
            wb_rdst      <= rdst_p0;
            wb_reg_write <= rw_p0;
          end
        end
        RESP: begin
          state        <= IDLE;
          wb_valid     <= 1'b0;
          wb_reg_write <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized transactions against a behavioural model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [15:0] alu_out;
  logic [15:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic        push;
  logic        pop;
  logic        reg_write;
  logic [2:0]  rdst;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [2:0]  wb_rdst;
  logic        wb_reg_write;
  logic [15:0] sp;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .alu_out      (alu_out),
    .store_data   (store_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .push         (push),
    .pop          (pop),
    .reg_write    (reg_write),
    .rdst         (rdst),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_rdst      (wb_rdst),
    .wb_reg_write (wb_reg_write),
    .sp           (sp)
  );

`ifdef CMP_STACK_EN
  localparam bit          STACK_ON = 1'b1;
  localparam logic [15:0] SP_INIT  = 16'h07FF;
`else
  localparam bit          STACK_ON = 1'b0;
  localparam logic [15:0] SP_INIT  = 16'h0000;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] sp_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    reg_write  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    dmem_ack = 1'b0;
    rst      = 1'b1;
    step();
    check("ready_in_rst", 32'(ex_ready), 32'd0);
    step();
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_addr", 32'(dmem_addr), 32'd0);
    check("rst_wdata", 32'(dmem_wdata), 32'd0);
    check("rst_wbv", 32'(wb_valid), 32'd0);
    check("rst_wbdata", 32'(wb_data), 32'd0);
    check("rst_wbrdst", 32'(wb_rdst), 32'd0);
    check("rst_wbrw", 32'(wb_reg_write), 32'd0);
    check("rst_sp", 32'(sp), 32'(SP_INIT));
    rst  = 1'b0;
    sp_m = SP_INIT;
    #1;
    check("ready_after_rst", 32'(ex_ready), 32'd1);
  endtask

  // One full transaction; expected access is derived from the priority rules and a model sp.
  task automatic run_txn(input logic [15:0] a, input logic [15:0] sd, input logic mr,
                         input logic mw, input logic pu, input logic po, input logic rw,
                         input logic [2:0] rd, input int lat, input logic [15:0] rdata);
    logic        pu_e;
    logic        po_e;
    logic        is_mem;
    logic        we;
    logic [15:0] addr;
    logic [15:0] exp_wb;
    pu_e   = pu && STACK_ON;
    po_e   = po && STACK_ON;
    is_mem = mr || mw || pu_e || po_e;
    if (pu_e) begin
      we = 1'b1; addr = sp_m;
    end else if (po_e) begin
      we = 1'b0; addr = sp_m + 16'd1;
    end else if (mw) begin
      we = 1'b1; addr = a;
    end else begin
      we = 1'b0; addr = a;
    end
    for (int i = 0; i < 8 && !ex_ready; i++) step();
    check("ready_idle", 32'(ex_ready), 32'd1);
    ex_valid   = 1'b1;
    alu_out    = a;
    store_data = sd;
    mem_read   = mr;
    mem_write  = mw;
    push       = pu;
    pop        = po;
    reg_write  = rw;
    rdst       = rd;
    dmem_ack   = 1'($urandom_range(0, 1));
    step();
    clear_inputs();
    dmem_ack = 1'b0;
    exp_wb   = a;
    if (is_mem) begin
      for (int c = 1; c <= lat; c++) begin
        check("acc_req", 32'(dmem_req), 32'd1);
        check("acc_addr", 32'(dmem_addr), 32'(addr));
        check("acc_we", 32'(dmem_we), 32'(we));
        if (we) check("acc_wdata", 32'(dmem_wdata), 32'(sd));
        check("acc_wbv", 32'(wb_valid), 32'd0);
        check("acc_ready", 32'(ex_ready), 32'd0);
        dmem_ack   = (c == lat);
        dmem_rdata = (c == lat) ? rdata : 16'($urandom);
        step();
      end
      dmem_ack = 1'($urandom_range(0, 1));
      if (!we) exp_wb = rdata;
      if (pu_e) sp_m = sp_m - 16'd1;
      else if (po_e) sp_m = sp_m + 16'd1;
      check("resp_req", 32'(dmem_req), 32'd0);
    end
    check("resp_wbv", 32'(wb_valid), 32'd1);
    check("resp_wbdata", 32'(wb_data), 32'(exp_wb));
    check("resp_rdst", 32'(wb_rdst), 32'(rd));
    check("resp_rw", 32'(wb_reg_write), 32'(rw));
    check("resp_ready", 32'(ex_ready), 32'd0);
    check("resp_sp", 32'(sp), 32'(sp_m));
    step();
    dmem_ack = 1'b0;
    check("idle_wbv", 32'(wb_valid), 32'd0);
    check("idle_rw", 32'(wb_reg_write), 32'd0);
    check("idle_hold", 32'(wb_data), 32'(exp_wb));
    check("idle_rdst", 32'(wb_rdst), 32'(rd));
    check("idle_sp", 32'(sp), 32'(sp_m));
  endtask

  initial begin
    rst        = 1'b1;
    alu_out    = '0;
    store_data = '0;
    rdst       = '0;
    dmem_rdata = '0;
    dmem_ack   = 1'b0;
    clear_inputs();
    do_reset();

    // ALU passthrough, then a 3-cycle load.
    run_txn(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1, 16'h0000);
    run_txn(16'h0010, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 3, 16'hBEEF);
    run_txn(16'h0020, 16'h1357, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 2, 16'hDEAD);

`ifdef CMP_STACK_EN
    run_txn(16'h0000, 16'hA5A5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1, 16'h0000);
    check("push_sp", 32'(sp), 32'h07FE);
    run_txn(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1, 16'hA5A5);
    check("pop_sp", 32'(sp), 32'h07FF);
`endif

    // Priority: read, write and push together.
    run_txn(16'h0300, 16'h7E7E, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 1, 16'h0000);

    // Reset arriving in ACCESS together with an ack.
    for (int i = 0; i < 8 && !ex_ready; i++) step();
    ex_valid  = 1'b1;
    alu_out   = 16'h0040;
    mem_read  = 1'b1;
    push      = 1'b1;
    reg_write = 1'b1;
    step();
    clear_inputs();
    check("mid_req", 32'(dmem_req), 32'd1);
    rst        = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 16'h9999;
    step();
    rst      = 1'b0;
    dmem_ack = 1'b0;
    sp_m     = SP_INIT;
    #1;
    check("mid_req_drop", 32'(dmem_req), 32'd0);
    check("mid_wbv", 32'(wb_valid), 32'd0);
    check("mid_sp", 32'(sp), 32'(sp_m));
    step();
    check("mid_wbv2", 32'(wb_valid), 32'd0);
    check("mid_rw2", 32'(wb_reg_write), 32'd0);

    for (int n = 0; n < 300; n++) begin
      run_txn(16'($urandom), 16'($urandom),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              int'($urandom_range(1, 4)), 16'($urandom));
    end

`ifdef CMP_STACK_EN
    do_reset();
    for (int n = 0; n < 2048; n++) begin
      run_txn(16'($urandom), 16'(n), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1, 16'h0000);
    end
    check("wrap_sp", 32'(sp), 32'hFFFF);
    run_txn(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 1, 16'hC0DE);
    check("wrap_pop_sp", 32'(sp), 32'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
